// File: rtl/dds_cmd_pkg.sv
// dds_cmd_pkg
//   Shared definitions for the multi-channel DDS command parser:
//   opcode values carried in the command byte high nibble, the reply
//   codes sent back over the UART, the parser state encoding, and a
//   helper that checks whether a command byte is acceptable.
package dds_cmd_pkg;

  localparam logic [3:0] OP_WRITE   = 4'h1;
  localparam logic [3:0] OP_ENABLE  = 4'h2;
  localparam logic [3:0] OP_DISABLE = 4'h3;
  localparam logic [3:0] OP_SET     = 4'h4;
  localparam logic [3:0] OP_READ    = 4'h5;

  localparam logic [7:0] RESP_ACK = 8'h06;
  localparam logic [7:0] RESP_NAK = 8'h15;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PAYLOAD,
    S_EXEC,
    S_READ_TX,
    S_RESP
  } state_t;

  // A command is accepted only when both the opcode is known and the
  // channel nibble addresses an existing channel.
  function automatic logic cmd_valid(input logic [7:0] b, input int num_ch);
    logic op_ok;
    op_ok = (b[7:4] >= OP_WRITE) && (b[7:4] <= OP_READ);
    return op_ok && (int'(b[3:0]) < num_ch);
  endfunction

endpackage

// File: rtl/dds_byte_timeout.sv
// dds_byte_timeout
//   Loadable down-counter. A kick reloads it to CYCLES; afterwards it
//   counts down to zero and stops.
//   Ports:
//     clk, rst  - clock, synchronous active-high reset (counter -> 0)
//     kick      - reload the counter to CYCLES
//     expired   - high in the last counting cycle (count==1, no kick),
//                 i.e. CYCLES cycles have elapsed since the last kick
//     active    - high while the counter is non-zero
module dds_byte_timeout #(
  parameter int CYCLES = 1200000
) (
  input  logic clk,
  input  logic rst,
  input  logic kick,
  output logic expired,
  output logic active
);

  localparam int CNT_W = (CYCLES > 1) ? $clog2(CYCLES + 1) : 1;

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (kick) begin
      count <= CNT_W'(CYCLES);
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == CNT_W'(1)) && !kick;
  assign active  = (count != '0);

endmodule

// File: rtl/dds_cmd_parser.sv
// dds_cmd_parser
//   Framed byte-command decoder sitting between a UART and NUM_CH DDS
//   phase-accumulator cores. Every command is answered with ACK or NAK;
//   truncated WRITE frames are abandoned after an inter-byte timeout.
//   Ports:
//     clk, rst   - clock, synchronous active-high reset
//     received   - one-cycle strobe, rx_byte valid
//     rx_byte    - received byte
//     transmit   - one-cycle strobe, tx_byte valid
//     tx_byte    - byte to send, held until the next transmit
//     tx_busy    - UART transmitter busy
//     en         - per-channel output enable
//     m          - tuning words, channel c at [c*W +: W]
//     set        - per-channel one-cycle load strobe
//     error      - high for ERR_HOLD_CYCLES after the latest NAK
import dds_cmd_pkg::*;

module dds_cmd_parser #(
  parameter int NUM_CH          = 4,
  parameter int WORD_BYTES      = 4,
  parameter int TIMEOUT_CYCLES  = 1200000,
  parameter int ERR_HOLD_CYCLES = 12000000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         received,
  input  logic [7:0]                   rx_byte,
  output logic                         transmit,
  output logic [7:0]                   tx_byte,
  input  logic                         tx_busy,
  output logic [NUM_CH-1:0]            en,
  output logic [NUM_CH*8*WORD_BYTES-1:0] m,
  output logic [NUM_CH-1:0]            set,
  output logic                         error
);

  localparam int W    = 8 * WORD_BYTES;
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int BI_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [BI_W-1:0] LAST_IDX = BI_W'(WORD_BYTES - 1);

  state_t            state;
  logic [3:0]        op_q;
  logic [CH_W-1:0]   ch_q;
  logic [BI_W-1:0]   byte_idx;
  logic [BI_W-1:0]   rd_cnt;
  logic [7:0]        resp_q;
  logic [W-1:0]      shadow;
  logic [W-1:0]      txsh;
  logic [W-1:0]      words [NUM_CH];

  logic cmd_ok;
  logic cmd_write;
  logic tx_free;
  logic to_kick;
  logic to_expired;
  logic to_active;
  logic nak_now;
  logic err_active;
  logic err_expired;
  logic unused_ok;

  assign cmd_ok    = cmd_valid(rx_byte, NUM_CH);
  assign cmd_write = (rx_byte[7:4] == OP_WRITE);

  // transmit is registered, so in the cycle right after a strobe the UART
  // has not yet had a chance to raise tx_busy; skip that cycle.
  assign tx_free = !tx_busy && !transmit;

  // The inter-byte timer restarts on the WRITE command byte and on every
  // payload byte; it is only consulted while collecting payload.
  assign to_kick = received &&
                   (((state == S_IDLE) && cmd_ok && cmd_write) ||
                    (state == S_PAYLOAD));

  assign nak_now = ((state == S_IDLE) && received && !cmd_ok) ||
                   ((state == S_PAYLOAD) && !received && to_expired);

  dds_byte_timeout #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_frame_timeout (
    .clk     (clk),
    .rst     (rst),
    .kick    (to_kick),
    .expired (to_expired),
    .active  (to_active)
  );

  // Every NAK decision reloads the full error hold.
  dds_byte_timeout #(
    .CYCLES (ERR_HOLD_CYCLES)
  ) u_err_hold (
    .clk     (clk),
    .rst     (rst),
    .kick    (nak_now),
    .expired (err_expired),
    .active  (err_active)
  );

  assign error     = err_active;
  assign unused_ok = &{1'b0, to_active, err_expired};

  for (genvar c = 0; c < NUM_CH; c++) begin : g_m
    assign m[c*W +: W] = words[c];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      op_q     <= '0;
      ch_q     <= '0;
      byte_idx <= '0;
      rd_cnt   <= '0;
      resp_q   <= '0;
      transmit <= 1'b0;
      tx_byte  <= '0;
      set      <= '0;
      en       <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        words[i] <= '0;
      end
    end else begin
      transmit <= 1'b0;
      set      <= '0;

      case (state)
        S_IDLE: begin
          if (received) begin
            op_q <= rx_byte[7:4];
            ch_q <= rx_byte[CH_W-1:0];
            if (!cmd_ok) begin
              resp_q <= RESP_NAK;
              state  <= S_RESP;
            end else if (cmd_write) begin
              byte_idx <= '0;
              state    <= S_PAYLOAD;
            end else begin
              state <= S_EXEC;
            end
          end
        end

        S_PAYLOAD: begin
          if (received) begin
            for (int b = 0; b < WORD_BYTES; b++) begin
              if (byte_idx == BI_W'(b)) begin
                shadow[8*b +: 8] <= rx_byte;
              end
            end
            byte_idx <= byte_idx + 1'b1;
            if (byte_idx == LAST_IDX) begin
              state <= S_EXEC;
            end
          end else if (to_expired) begin
            // Partial shadow is simply abandoned; words[] never sees it.
            resp_q <= RESP_NAK;
            state  <= S_RESP;
          end
        end

        S_EXEC: begin
          resp_q <= RESP_ACK;
          case (op_q)
            OP_WRITE:   words[ch_q] <= shadow;
            OP_ENABLE:  en[ch_q]    <= 1'b1;
            OP_DISABLE: en[ch_q]    <= 1'b0;
            OP_SET:     set[ch_q]   <= 1'b1;
            OP_READ: begin
              txsh   <= words[ch_q];
              rd_cnt <= '0;
            end
            default: ;
          endcase
          // The ACK goes out straight from here when the UART is free,
          // giving a two-cycle turnaround from the last frame byte.
          if (op_q == OP_READ) begin
            state <= S_READ_TX;
          end else if (tx_free) begin
            transmit <= 1'b1;
            tx_byte  <= RESP_ACK;
            state    <= S_IDLE;
          end else begin
            state <= S_RESP;
          end
        end

        S_READ_TX: begin
          if (tx_free) begin
            transmit <= 1'b1;
            tx_byte  <= txsh[7:0];
            txsh     <= txsh >> 8;
            rd_cnt   <= rd_cnt + 1'b1;
            if (rd_cnt == LAST_IDX) begin
              resp_q <= RESP_ACK;
              state  <= S_RESP;
            end
          end
        end

        S_RESP: begin
          if (tx_free) begin
            transmit <= 1'b1;
            tx_byte  <= resp_q;
            state    <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dds_cmd_parser.sv
// tb_dds_cmd_parser
//   Self-checking bench for dds_cmd_parser with a behavioural model of the
//   channel words/enables, a simple UART transmitter busy model and a
//   log of transmitted bytes and set pulses.
module tb_dds_cmd_parser;

  localparam int NUM_CH = 4;
  localparam int WORD_BYTES = 4;
  localparam int W = 8 * WORD_BYTES;
  localparam int TO = 100;
  localparam int HOLD = 300;

  logic clk = 1'b0;
  logic rst;
  logic received;
  logic [7:0] rx_byte;
  logic transmit;
  logic [7:0] tx_byte;
  logic tx_busy;
  logic [NUM_CH-1:0] en;
  logic [NUM_CH*W-1:0] m;
  logic [NUM_CH-1:0] set;
  logic error;

  always #5 clk = ~clk;

  dds_cmd_parser #(
    .NUM_CH (NUM_CH),
    .WORD_BYTES (WORD_BYTES),
    .TIMEOUT_CYCLES (TO),
    .ERR_HOLD_CYCLES (HOLD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .received (received),
    .rx_byte (rx_byte),
    .transmit (transmit),
    .tx_byte (tx_byte),
    .tx_busy (tx_busy),
    .en (en),
    .m (m),
    .set (set),
    .error (error)
  );

  int errors = 0;
  int checks = 0;

  logic [W-1:0] mm [NUM_CH];
  logic [NUM_CH-1:0] men;
  logic [7:0] txq [$];
  logic [NUM_CH-1:0] setq [$];
  int busy_len = 0;
  int busy_cnt = 0;
  int busy_viol = 0;

  // UART transmitter model and output monitor, all on the falling edge.
  initial begin : uart_model
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (set != '0) setq.push_back(set);
      if (transmit) begin
        txq.push_back(tx_byte);
        if (tx_busy) busy_viol++;
        if (busy_len > 0) begin
          tx_busy = 1'b1;
          busy_cnt = busy_len;
        end
      end else if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) tx_busy = 1'b0;
      end
    end
  end

  function automatic logic [NUM_CH*W-1:0] exp_flat();
    logic [NUM_CH*W-1:0] f;
    for (int c = 0; c < NUM_CH; c++) f[c*W +: W] = mm[c];
    return f;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) mm[c] = '0;
    men = '0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) @(negedge clk);
    received = 1'b1;
    rx_byte = b;
    @(negedge clk);
    received = 1'b0;
  endtask

  task automatic wait_tx(input int n, input int budget, input string name);
    int k = 0;
    while (txq.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    repeat (4) @(negedge clk);
    checks++;
    if (txq.size() != n) begin
      errors++;
      $display("FAIL %s tx_count: got %0d want %0d", name, txq.size(), n);
    end
  endtask

  task automatic check_state(input string name);
    checks++;
    if (m !== exp_flat() || en !== men) begin
      errors++;
      $display("FAIL %s state: m=%h en=%b want m=%h en=%b", name, m, en, exp_flat(), men);
    end
  endtask

  // Sends one command (plus payload if it is a valid WRITE), updates the
  // model from the command rules, then compares replies, set pulses and state.
  task automatic run_cmd(input logic [7:0] cmd, input logic [W-1:0] word, input string name);
    logic [3:0] op = cmd[7:4];
    int ch = int'(cmd[3:0]);
    bit ok;
    logic [7:0] exp [$];
    logic [NUM_CH-1:0] eset = '0;
    ok = (op >= 4'h1) && (op <= 4'h5) && (ch < NUM_CH);
    txq.delete();
    setq.delete();
    send_byte(cmd, $urandom_range(0, 2));
    if (ok && op == 4'h1)
      for (int i = 0; i < WORD_BYTES; i++) send_byte(word[8*i +: 8], $urandom_range(0, 3));
    if (!ok) exp.push_back(8'h15);
    else begin
      case (op)
        4'h1: mm[ch] = word;
        4'h2: men[ch] = 1'b1;
        4'h3: men[ch] = 1'b0;
        4'h4: eset[ch] = 1'b1;
        4'h5: for (int i = 0; i < WORD_BYTES; i++) exp.push_back(mm[ch][8*i +: 8]);
        default: ;
      endcase
      exp.push_back(8'h06);
    end
    wait_tx(exp.size(), 400, name);
    for (int i = 0; i < exp.size(); i++) begin
      if (i < txq.size()) begin
        checks++;
        if (txq[i] !== exp[i]) begin
          errors++;
          $display("FAIL %s tx[%0d]: got %h want %h", name, i, txq[i], exp[i]);
        end
      end
    end
    checks++;
    if ((eset == '0) ? (setq.size() != 0) : (setq.size() != 1 || setq[0] !== eset)) begin
      errors++;
      $display("FAIL %s set: pulses=%0d first=%b want %b", name, setq.size(),
               (setq.size() > 0) ? setq[0] : '0, eset);
    end
    check_state(name);
    if (!ok) begin
      checks++;
      if (error !== 1'b1) begin
        errors++;
        $display("FAIL %s error: got %b want 1", name, error);
      end
    end
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({transmit, tx_byte, en, set, error} !== '0 || m !== '0) begin
      errors++;
      $display("FAIL %s zero: tx=%b txb=%h en=%b set=%b err=%b m=%h want all 0",
               name, transmit, tx_byte, en, set, error, m);
    end
  endtask

  task automatic apply_rst(input string name);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero(name);
    rst = 1'b0;
    model_reset();
    txq.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    received = 1'b0;
    rx_byte = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("reset_release");
  endtask

  task automatic test_write();
    busy_len = 0;
    txq.delete();
    send_byte(8'h12, 0);
    send_byte(8'h78, 1);
    send_byte(8'h56, 1);
    send_byte(8'h34, 1);
    send_byte(8'h12, 0);
    checks++;
    if (transmit !== 1'b0) begin
      errors++;
      $display("FAIL latency_early: transmit=%b want 0", transmit);
    end
    @(negedge clk);
    checks++;
    if (transmit !== 1'b1 || tx_byte !== 8'h06) begin
      errors++;
      $display("FAIL latency_ack: transmit=%b tx_byte=%h want 1/06", transmit, tx_byte);
    end
    mm[2] = 32'h12345678;
    repeat (4) @(negedge clk);
    checks++;
    if (txq.size() != 1) begin
      errors++;
      $display("FAIL write_tx_count: got %0d want 1", txq.size());
    end
    check_state("write");
    checks++;
    if (error !== 1'b0) begin
      errors++;
      $display("FAIL write_error: got %b want 0", error);
    end
  endtask

  task automatic test_ctrl();
    busy_len = 3;
    run_cmd(8'h41, '0, "set1");
    run_cmd(8'h21, '0, "enable1");
    run_cmd(8'h31, '0, "disable1");
  endtask

  task automatic test_read();
    busy_len = 20;
    run_cmd(8'h52, '0, "read2");
  endtask

  task automatic test_nak();
    busy_len = 2;
    run_cmd(8'h17, '0, "bad_channel");
    run_cmd(8'h90, '0, "bad_opcode");
    repeat (HOLD + 20) @(negedge clk);
    checks++;
    if (error !== 1'b0) begin
      errors++;
      $display("FAIL error_clear: got %b want 0", error);
    end
    run_cmd(8'h99, '0, "nak_a");
    repeat (200) @(negedge clk);
    run_cmd(8'hF0, '0, "nak_b");
    repeat (200) @(negedge clk);
    checks++;
    if (error !== 1'b1) begin
      errors++;
      $display("FAIL error_restart_hold: got %b want 1", error);
    end
    repeat (150) @(negedge clk);
    checks++;
    if (error !== 1'b0) begin
      errors++;
      $display("FAIL error_restart_clear: got %b want 0", error);
    end
  endtask

  task automatic test_timeout();
    busy_len = 2;
    txq.delete();
    send_byte(8'h10, 0);
    send_byte(8'hAA, 1);
    send_byte(8'hBB, 1);
    repeat (TO - 10) @(negedge clk);
    checks++;
    if (txq.size() != 0) begin
      errors++;
      $display("FAIL timeout_early: got %0d bytes want 0", txq.size());
    end
    wait_tx(1, 60, "timeout");
    if (txq.size() > 0) begin
      checks++;
      if (txq[0] !== 8'h15) begin
        errors++;
        $display("FAIL timeout_nak: got %h want 15", txq[0]);
      end
    end
    check_state("timeout");
    checks++;
    if (error !== 1'b1) begin
      errors++;
      $display("FAIL timeout_error: got %b want 1", error);
    end
    run_cmd(8'h10, 32'hCAFEF00D, "after_timeout");
  endtask

  task automatic test_drop();
    logic [7:0] exp [$];
    busy_len = 10;
    txq.delete();
    for (int i = 0; i < WORD_BYTES; i++) exp.push_back(mm[0][8*i +: 8]);
    exp.push_back(8'h06);
    send_byte(8'h50, 0);
    send_byte(8'h22, 3);
    wait_tx(exp.size(), 400, "drop");
    for (int i = 0; i < exp.size() && i < txq.size(); i++) begin
      checks++;
      if (txq[i] !== exp[i]) begin
        errors++;
        $display("FAIL drop tx[%0d]: got %h want %h", i, txq[i], exp[i]);
      end
    end
    check_state("drop");
  endtask

  task automatic test_reset_midframe();
    int k;
    busy_len = 2;
    txq.delete();
    send_byte(8'h10, 0);
    send_byte(8'h11, 0);
    apply_rst("rst_payload");
    repeat (TO + 50) @(negedge clk);
    checks++;
    if (txq.size() != 0) begin
      errors++;
      $display("FAIL rst_payload_quiet: got %0d bytes want 0", txq.size());
    end
    run_cmd(8'h11, 32'h0BADBEEF, "rst_write");
    busy_len = 20;
    txq.delete();
    send_byte(8'h51, 0);
    k = 0;
    while (txq.size() < 1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (txq.size() < 1) begin
      errors++;
      $display("FAIL rst_read_start: got %0d bytes want 1", txq.size());
    end
    apply_rst("rst_read_tx");
    repeat (60) @(negedge clk);
    checks++;
    if (txq.size() != 0) begin
      errors++;
      $display("FAIL rst_read_quiet: got %0d bytes want 0", txq.size());
    end
    run_cmd(8'h51, '0, "after_rst_read");
  endtask

  task automatic test_random();
    logic [7:0] cmd;
    int kind;
    for (int n = 0; n < 40; n++) begin
      busy_len = $urandom_range(0, 4);
      kind = $urandom_range(0, 6);
      if (kind <= 4) cmd = {4'(kind + 1), 4'($urandom_range(0, NUM_CH - 1))};
      else if (kind == 5) cmd = {4'($urandom_range(6, 15)), 4'($urandom_range(0, 15))};
      else cmd = {4'($urandom_range(1, 5)), 4'($urandom_range(NUM_CH, 15))};
      run_cmd(cmd, W'($urandom()), "random");
    end
  endtask

  initial begin
    rst = 1'b1;
    received = 1'b0;
    rx_byte = '0;
    @(negedge clk);
    test_reset();
    test_write();
    test_ctrl();
    test_read();
    test_nak();
    test_timeout();
    test_drop();
    test_reset_midframe();
    test_random();
    checks++;
    if (busy_viol != 0) begin
      errors++;
      $display("FAIL tx_while_busy: got %0d strobes want 0", busy_viol);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dds_cmd_parser.md
Name: dds_cmd_parser

Overview:
- Multi-channel successor to the single-channel UART command decoder; sits between uart_rx/uart_tx and N DDS phase-accumulator cores.
- Decodes framed byte commands carrying a channel index and a full tuning word, with readback.
- Replies ACK or NAK to every command, recovers from truncated frames by inter-byte timeout, and drives per-channel enable, tuning word and set strobe.

Parameters:
NUM_CH, 4, number of DDS channels (1..16)
WORD_BYTES, 4, bytes per tuning word; word width W = 8*WORD_BYTES
TIMEOUT_CYCLES, 1200000, max clk cycles between bytes of one frame (100 ms at 12 MHz)
ERR_HOLD_CYCLES, 12000000, cycles error stays high after a NAK

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
received  in  1  one-cycle strobe, rx_byte valid
rx_byte  in  8  received byte
transmit  out  1  one-cycle strobe, tx_byte valid
tx_byte  out  8  byte to send
tx_busy  in  1  UART transmitter busy; transmit never pulsed while high
en  out  NUM_CH  per-channel output enable
m  out  NUM_CH*W  tuning words; channel c at bits [c*W +: W]
set  out  NUM_CH  per-channel one-cycle load strobe
error  out  1  high for ERR_HOLD_CYCLES after any NAK

Behaviour:
- Reset: all outputs 0, all tuning words 0, state IDLE, counters 0. rst mid-frame or mid-reply abandons it with no reply.
- Command byte: [7:4] opcode, [3:0] channel. WRITE=0x1 (+WORD_BYTES payload, LSB first), ENABLE=0x2, DISABLE=0x3, SET=0x4, READ=0x5. ACK=0x06, NAK=0x15.
- Unknown opcode or channel >= NUM_CH → NAK, no side effects, payload not expected.
- States:
  - IDLE: on received, decode the byte. WRITE → PAYLOAD with byte index 0. Valid other opcodes → EXEC. Invalid → RESP with NAK.
  - PAYLOAD: each received byte goes to a shadow word at byte index, index +1. Timeout counter resets on each byte. After the last byte → EXEC. If the counter reaches TIMEOUT_CYCLES → RESP with NAK; the shadow is discarded and m is unchanged.
  - EXEC (1 cycle):
    - WRITE copies the shadow to m[ch] atomically; partial words are never visible.
    - ENABLE/DISABLE sets/clears en[ch].
    - SET pulses set[ch] for exactly this cycle.
    - READ loads the tx shift with m[ch].
    - All valid opcodes → RESP with ACK, except READ → READ_TX.
  - READ_TX: sends WORD_BYTES bytes of m[ch], LSB first, then → RESP with ACK.
  - RESP: waits for tx_busy=0, pulses transmit one cycle with tx_byte=ACK/NAK → IDLE.
- tx_byte holds its value until the next transmit. Between consecutive transmits, wait at least one cycle after transmit for tx_busy to rise before sampling it again.
- Latency: with tx_busy low, the ACK transmit strobe occurs 2 cycles after the received strobe of the final frame byte.
- received while in EXEC, READ_TX or RESP: byte is dropped silently.
- Error: every NAK reloads the hold counter and sets error=1. error clears when the counter expires. A NAK during a hold restarts the full hold.
- en, m and set of other channels are never disturbed by a command to channel ch.

Decomposition:
- Package dds_cmd_pkg: opcode constants, ACK/NAK codes, state enum.
- Sub-module dds_byte_timeout: loadable down-counter with kick and expired output. Reused for the error hold with ERR_HOLD_CYCLES.

Test Plan:
1. NUM_CH=4, W=32: send 0x12,0x78,0x56,0x34,0x12 → m[2]=0x12345678, other words 0, one transmit of 0x06, error=0.
2. Send 0x41 → set=4'b0010 for exactly one cycle; 0x21 → en[1]=1; 0x31 → en[1]=0. Each command returns 0x06.
3. After test 1, send 0x52 → transmits 0x78,0x56,0x34,0x12,0x06 in order. Hold tx_busy high 20 cycles after each; no transmit occurs while tx_busy=1.
4. Send 0x17 (channel 7 ≥ NUM_CH) and 0x90 (bad opcode) → each returns 0x15, error=1, all m/en unchanged.
5. Send 0x10,0xAA,0xBB then idle TIMEOUT_CYCLES (bench override 100) → NAK 0x15, m[0] unchanged. Next valid frame decodes correctly.
6. Assert rst during PAYLOAD and during READ_TX → no transmit; all outputs 0 the cycle after. The next command succeeds.
